fan_mode_sequencer: RTL and testbench

- Sequences the range-hood fan through its operating modes: standby, level 1/2, hurricane (level 3), post-hurricane exit delay, and self-clean.
- Owns the fan-level resource and every countdown derived from the 1 Hz tick.
- Sits between power/button conditioning and the fan/display outputs.
- Button inputs are already debounced one-cycle pulses.

---
 rtl/fan_mode_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fan_mode_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_mode_sequencer.sv
// Range-hood fan mode sequencer: standby, levels 1-3, exit delay, self-clean.
// Optional build macro: HURRICANE_ONCE_EN (hurricane allowed once per session).
module fan_mode_sequencer #(
    parameter int HURRICANE_SEC  = 60,
    parameter int EXIT_DELAY_SEC = 60,
    parameter int CLEAN_SEC      = 180,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             power_on,
    input  logic             menu_pulse,
    input  logic             lvl1_pulse,
    input  logic             lvl2_pulse,
    input  logic             lvl3_pulse,
    input  logic             clean_pulse,
    output logic [2:0]       state,
    output logic [1:0]       fan_lvl,
    output logic [CNT_W-1:0] cnt_left,
    output logic             menu_armed,
    output logic             clean_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_STANDBY  = 3'd1,
        S_LVL1     = 3'd2,
        S_LVL2     = 3'd3,
        S_LVL3     = 3'd4,
        S_EXIT_DLY = 3'd5,
        S_CLEAN    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] HUR_LD   = CNT_W'(HURRICANE_SEC);
    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY_SEC);
    localparam logic [CNT_W-1:0] CLEAN_LD = CNT_W'(CLEAN_SEC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             used_q, used_d;
    logic             done_q, done_d;
    logic [1:0]       fan_q;
    logic             busy_q;
    logic             lvl3_ok;
    logic             expire;

`ifdef HURRICANE_ONCE_EN
    assign lvl3_ok = !used_q;
`else
    assign lvl3_ok = 1'b1;
`endif

    // A tick on the last remaining second ends the timed state.
    assign expire = tick_1hz && (cnt_q == ONE);

    function automatic logic [1:0] fan_of(input state_t s);
        unique case (s)
            S_LVL1:     fan_of = 2'd1;
            S_LVL2:     fan_of = 2'd2;
            S_LVL3:     fan_of = 2'd3;
            S_EXIT_DLY: fan_of = 2'd2;
            default:    fan_of = 2'd0;
        endcase
    endfunction

    // Next-state, countdown and flag decisions; power loss overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        used_d  = used_q;
        done_d  = 1'b0;
        if (!power_on) begin
            state_d = S_OFF;
            cnt_d   = '0;
            armed_d = 1'b0;
            used_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_STANDBY;
                end
                S_STANDBY: begin
                    if (menu_pulse) begin
                        armed_d = !armed_q;
                    end else if (armed_q) begin
                        if (lvl3_pulse && lvl3_ok) begin
                            state_d = S_LVL3;
                            cnt_d   = HUR_LD;
                            used_d  = 1'b1;
                            armed_d = 1'b0;
                        end else if (lvl2_pulse) begin
                            state_d = S_LVL2;
                            armed_d = 1'b0;
                        end else if (lvl1_pulse) begin
                            state_d = S_LVL1;
                            armed_d = 1'b0;
                        end else if (clean_pulse) begin
                            state_d = S_CLEAN;
                            cnt_d   = CLEAN_LD;
                            armed_d = 1'b0;
                        end
                    end
                end
                S_LVL1, S_LVL2: begin
                    if (menu_pulse) begin
                        state_d = S_STANDBY;
                    end else if (lvl2_pulse) begin
                        state_d = S_LVL2;
                    end else if (lvl1_pulse) begin
                        state_d = S_LVL1;
                    end
                end
                S_LVL3: begin
                    if (menu_pulse) begin
                        state_d = S_EXIT_DLY;
                        cnt_d   = EXIT_LD;
                    end else if (expire) begin
                        state_d = S_LVL2;
                        cnt_d   = '0;
                    end else if (tick_1hz && cnt_q > ONE) begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_EXIT_DLY, S_CLEAN: begin
                    if (expire) begin
                        state_d = S_STANDBY;
                        cnt_d   = '0;
                        done_d  = (state_q == S_CLEAN);
                    end else if (tick_1hz && cnt_q > ONE) begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            endcase
        end
    end

    // Register state and every output so each reflects the state just entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            used_q  <= 1'b0;
            done_q  <= 1'b0;
            fan_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            used_q  <= used_d;
            done_q  <= done_d;
            fan_q   <= fan_of(state_d);
            busy_q  <= (state_d == S_LVL3) ||
                       (state_d == S_EXIT_DLY) ||
                       (state_d == S_CLEAN);
        end
    end

    assign state      = state_q;
    assign fan_lvl    = fan_q;
    assign cnt_left   = cnt_q;
    assign menu_armed = armed_q;
    assign clean_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fan_mode_sequencer.sv
// Self-checking bench for fan_mode_sequencer: directed plan plus random run
// against a behavioural model of the mode rules.
module tb_fan_mode_sequencer;

    localparam int HS = 3;
    localparam int ES = 2;
    localparam int CS = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick_1hz = 1'b0;
    logic          power_on = 1'b0;
    logic          menu_pulse = 1'b0;
    logic          lvl1_pulse = 1'b0;
    logic          lvl2_pulse = 1'b0;
    logic          lvl3_pulse = 1'b0;
    logic          clean_pulse = 1'b0;
    logic [2:0]    state;
    logic [1:0]    fan_lvl;
    logic [CW-1:0] cnt_left;
    logic          menu_armed;
    logic          clean_done;
    logic          busy;

    fan_mode_sequencer #(
        .HURRICANE_SEC (HS),
        .EXIT_DELAY_SEC(ES),
        .CLEAN_SEC     (CS),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .power_on   (power_on),
        .menu_pulse (menu_pulse),
        .lvl1_pulse (lvl1_pulse),
        .lvl2_pulse (lvl2_pulse),
        .lvl3_pulse (lvl3_pulse),
        .clean_pulse(clean_pulse),
        .state      (state),
        .fan_lvl    (fan_lvl),
        .cnt_left   (cnt_left),
        .menu_armed (menu_armed),
        .clean_done (clean_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: mode number (0..6 as on the state port), seconds
    // left, armed flag, hurricane-used flag, clean-finished pulse.
    int m_mode = 0;
    int m_secs = 0;
    bit m_arm = 0;
    bit m_used = 0;
    bit m_done = 0;
    int fan_tab[7] = '{0, 0, 1, 2, 3, 2, 0};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_secs = 0;
        m_arm = 0;
        m_used = 0;
        m_done = 0;
    endtask

    task automatic m_enter(input int mode);
        m_mode = mode;
        m_arm = 0;
        m_secs = (mode == 4) ? HS : (mode == 6) ? CS : 0;
        if (mode == 4) m_used = 1;
    endtask

    task automatic m_step();
        bit ok;
`ifdef HURRICANE_ONCE_EN
        ok = !m_used;
`else
        ok = 1;
`endif
        m_done = 0;
        if (!power_on) begin
            m_mode = 0;
            m_secs = 0;
            m_arm = 0;
            m_used = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (menu_pulse) m_arm = !m_arm;
            else if (m_arm) begin
                if (lvl3_pulse && ok) m_enter(4);
                else if (lvl2_pulse) m_enter(3);
                else if (lvl1_pulse) m_enter(2);
                else if (clean_pulse) m_enter(6);
            end
        end else if (m_mode == 2 || m_mode == 3) begin
            if (menu_pulse) m_mode = 1;
            else if (lvl2_pulse) m_mode = 3;
            else if (lvl1_pulse) m_mode = 2;
        end else if (m_mode == 4 && menu_pulse) begin
            m_mode = 5;
            m_secs = ES;
        end else if (tick_1hz) begin
            if (m_secs > 1) begin
                m_secs--;
            end else begin
                m_done = (m_mode == 6);
                m_mode = (m_mode == 4) ? 3 : 1;
                m_secs = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("state", int'(state), m_mode);
        chk("fan_lvl", int'(fan_lvl), fan_tab[m_mode]);
        chk("cnt_left", int'(cnt_left), m_secs);
        chk("menu_armed", int'(menu_armed), int'(m_arm));
        chk("clean_done", int'(clean_done), int'(m_done));
        chk("busy", int'(busy), int'(m_mode >= 4));
    endtask

    task automatic clr_keys();
        tick_1hz = 0;
        menu_pulse = 0;
        lvl1_pulse = 0;
        lvl2_pulse = 0;
        lvl3_pulse = 0;
        clean_pulse = 0;
    endtask

    task automatic step();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
        clr_keys();
    endtask

    task automatic key(input int k);
        menu_pulse = (k == 0);
        lvl1_pulse = (k == 1);
        lvl2_pulse = (k == 2);
        lvl3_pulse = (k == 3);
        clean_pulse = (k == 4);
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1;
            step();
        end
    endtask

    task automatic power_cycle();
        power_on = 0;
        step();
        power_on = 1;
        step();
    endtask

    initial begin
        reset = 1;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_cnt", int'(cnt_left), 0);
        chk("rst_fan", int'(fan_lvl), 0);
        reset = 0;
        m_reset();
        power_on = 1;
        step();
        chk("standby", int'(state), 1);
        key(2);
        chk("unarmed_key", int'(state), 1);
        key(0);
        chk("armed", int'(menu_armed), 1);
        key(1);
        chk("lvl1_fan", int'(fan_lvl), 1);
        key(2);
        chk("lvl2", int'(state), 3);
        key(0);
        chk("back_sb", int'(state), 1);
        key(0);
        key(3);
        chk("lvl3_cnt", int'(cnt_left), 3);
        ticks(3);
        chk("auto_lvl2", int'(state), 3);
        chk("auto_cnt", int'(cnt_left), 0);
        key(0);
        power_cycle();
        key(0);
        key(3);
        ticks(1);
        key(0);
        chk("exit_dly", int'(state), 5);
        chk("exit_cnt", int'(cnt_left), 2);
        ticks(2);
        chk("exit_done", int'(state), 1);
        key(0);
        key(3);
`ifdef HURRICANE_ONCE_EN
        chk("second_hur", int'(state), 1);
`else
        chk("second_hur", int'(state), 4);
`endif
        power_cycle();
        key(0);
        key(4);
        chk("clean_cnt", int'(cnt_left), 4);
        ticks(4);
        chk("clean_pulse", int'(clean_done), 1);
        step();
        chk("clean_one", int'(clean_done), 0);
        key(0);
        key(4);
        ticks(2);
        power_on = 0;
        step();
        chk("abort_cnt", int'(cnt_left), 0);
        power_on = 1;
        step();
        key(0);
        lvl1_pulse = 1;
        lvl3_pulse = 1;
        step();
        chk("lvl3_prio", int'(state), 4);
        ticks(2);
        menu_pulse = 1;
        tick_1hz = 1;
        step();
        chk("menu_beats_exp", int'(state), 5);
        ticks(2);
        key(0);
        key(4);
        ticks(1);
        #3;
        reset = 1;
        #1;
        m_reset();
        compare_all();
        #2;
        reset = 0;
        for (int c = 0; c < 3000; c++) begin
            power_on = ($urandom_range(99) >= 3);
            tick_1hz = ($urandom_range(99) < 35);
            if ($urandom_range(99) < 30) begin
                int k;
                k = $urandom_range(4);
                menu_pulse = (k == 0);
                lvl1_pulse = (k == 1);
                lvl2_pulse = (k == 2);
                lvl3_pulse = (k == 3);
                clean_pulse = (k == 4);
            end
            step();
            if ($urandom_range(299) == 0) begin
                #2;
                reset = 1;
                #1;
                m_reset();
                compare_all();
                #1;
                reset = 0;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
